pulse_queue: RTL and testbench

Single-clock pulse queue that sits directly upstream of the pulse-CDC on side A. It accepts bursts of 1-clock-wide event pulses, counts how many are pending, and issues them one at a time to the CDC stage only when that stage reports not-busy. No event is lost unless the pending counter saturates, and losses are flagged.

---
 rtl/pulse_queue_pkg.sv | 13 +
 rtl/pulse_queue_if.sv | 36 +++
 rtl/pulse_queue_sat_counter.sv | 33 +++
 rtl/pulse_queue.sv | 76 +++++++
 tb/tb_pulse_queue.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/pulse_queue_pkg.sv
// Shared FSM state encoding for the pulse queue.
// Optional drop statistics: define PULSE_QUEUE_STATS_EN.
package pulse_queue_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE = 2'd0,
      S_HOLD = 2'd1,
      S_WAIT = 2'd2
   } state_t;

endpackage

// File: rtl/pulse_queue_if.sv
// Event, CDC-busy and status bundle of the pulse queue.
// slave = queue side, master = driver/observer side.
interface pulse_queue_if #(
   parameter int CNT_W  = 8,
   parameter int DROP_W = 16
);

   logic              i_pulse;
   logic              i_busy;
   logic              i_clr_ovf;
   logic              o_pulse;
   logic [CNT_W-1:0]  o_pending;
   logic              o_ovf;
   logic [DROP_W-1:0] o_drop_cnt;

   modport slave (
      input  i_pulse,
      input  i_busy,
      input  i_clr_ovf,
      output o_pulse,
      output o_pending,
      output o_ovf,
      output o_drop_cnt
   );

   modport master (
      output i_pulse,
      output i_busy,
      output i_clr_ovf,
      input  o_pulse,
      input  o_pending,
      input  o_ovf,
      input  o_drop_cnt
   );

endinterface

// File: rtl/pulse_queue_sat_counter.sv
// Up/down counter that clamps at zero and all-ones.
// Clear with a coincident increment lands on 1.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_inc,
   input  logic         i_dec,
   input  logic         i_clr,
   output logic [W-1:0] o_q
);

   localparam logic [W-1:0] MAX = {W{1'b1}};
   localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

   logic [W-1:0] r_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_q <= '0;
      end else if (i_clr) begin
         r_q <= i_inc ? ONE : '0;
      end else if (i_inc && !i_dec) begin
         if (r_q != MAX) r_q <= r_q + ONE;
      end else if (i_dec && !i_inc) begin
         if (r_q != '0) r_q <= r_q - ONE;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/pulse_queue.sv
// Queues 1-cycle events and meters them one at a time into a pulse CDC.
// Optional drop counter: define PULSE_QUEUE_STATS_EN.
module pulse_queue
   import pulse_queue_pkg::*;
#(
   parameter int CNT_W  = 8,
   parameter int DROP_W = 16
) (
   input  logic         i_clk,
   input  logic         i_rst,
   pulse_queue_if.slave bus
);

   state_t           r_state;
   logic             r_pulse;
   logic             r_ovf;
   logic [CNT_W-1:0] w_pending;
   logic             w_issue;
   logic             w_full;
   logic             w_drop;

   assign w_full  = &w_pending;
   assign w_issue = (r_state == S_IDLE) && (w_pending != '0) && !bus.i_busy;
   // An issue frees a slot, so a pulse arriving with it is never dropped.
   assign w_drop  = bus.i_pulse && w_full && !w_issue;

   sat_counter #(.W(CNT_W)) u_pending (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_inc (bus.i_pulse),
      .i_dec (w_issue),
      .i_clr (1'b0),
      .o_q   (w_pending)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_pulse <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_pulse <= w_issue;
         if (w_drop)             r_ovf <= 1'b1;
         else if (bus.i_clr_ovf) r_ovf <= 1'b0;
         unique case (r_state)
            S_IDLE: if (w_issue) r_state <= S_HOLD;
            // CDC busy is not visible yet in the cycle after the pulse
            S_HOLD: r_state <= S_WAIT;
            S_WAIT: if (!bus.i_busy) r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.o_pulse   = r_pulse;
   assign bus.o_pending = w_pending;
   assign bus.o_ovf     = r_ovf;

`ifdef PULSE_QUEUE_STATS_EN
   logic [DROP_W-1:0] w_drop_cnt;

   sat_counter #(.W(DROP_W)) u_drops (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_inc (w_drop),
      .i_dec (1'b0),
      .i_clr (bus.i_clr_ovf),
      .o_q   (w_drop_cnt)
   );

   assign bus.o_drop_cnt = w_drop_cnt;
`else
   assign bus.o_drop_cnt = {DROP_W{1'b0}};
`endif

endmodule

// File: tb/tb_pulse_queue.sv
// Directed bench: 8-bit queue for timing/reset, 2-bit queue for overflow.
module tb_pulse_queue;
   import pulse_queue_pkg::*;

`ifdef PULSE_QUEUE_STATS_EN
   localparam int STATS = 1;
`else
   localparam int STATS = 0;
`endif

   logic i_clk = 1'b0;
   logic i_rst = 1'b1;
   always #5 i_clk = ~i_clk;

   pulse_queue_if #(.CNT_W(8), .DROP_W(16)) bus0 ();
   pulse_queue_if #(.CNT_W(2), .DROP_W(16)) bus1 ();

   pulse_queue #(.CNT_W(8), .DROP_W(16)) dut0 (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .bus   (bus0.slave)
   );

   pulse_queue #(.CNT_W(2), .DROP_W(16)) dut1 (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .bus   (bus1.slave)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int pc0 = 0;
   int pc1 = 0;
   int pk0 = 0;
   int b2b = 0;
   int bcnt = 0;
   bit auto_busy = 0;
   logic prev0 = 0;
   logic prev1 = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance one edge, sample 1ns later, track pulse stats and busy model.
   task automatic tick();
      @(posedge i_clk);
      #1;
      if (bus0.o_pulse) begin
         pc0++;
         if (prev0) b2b++;
      end
      if (bus1.o_pulse) begin
         pc1++;
         if (prev1) b2b++;
      end
      prev0 = bus0.o_pulse;
      prev1 = bus1.o_pulse;
      if (int'(bus0.o_pending) > pk0) pk0 = int'(bus0.o_pending);
      if (auto_busy) begin
         if (bus0.o_pulse) bcnt = 10;
         bus0.i_busy = (bcnt > 0);
         if (bcnt > 0) bcnt--;
      end
   endtask

   initial begin
      bus0.i_pulse = 0; bus0.i_busy = 0; bus0.i_clr_ovf = 0;
      bus1.i_pulse = 0; bus1.i_busy = 0; bus1.i_clr_ovf = 0;
      i_rst = 1;
      repeat (2) tick();
      chk("rst_pulse", 32'(bus0.o_pulse), 0);
      chk("rst_pend", 32'(bus0.o_pending), 0);
      chk("rst_ovf", 32'(bus0.o_ovf), 0);
      chk("rst_drop", 32'(bus0.o_drop_cnt), 0);
      chk("rst_state", 32'(dut0.r_state), 32'(S_IDLE));
      i_rst = 0;
      tick();

      // single pulse latency
      bus0.i_pulse = 1;
      tick();
      bus0.i_pulse = 0;
      chk("t1_pend1", 32'(bus0.o_pending), 1);
      chk("t1_nopulse", 32'(bus0.o_pulse), 0);
      tick();
      chk("t1_pulse", 32'(bus0.o_pulse), 1);
      chk("t1_pend0", 32'(bus0.o_pending), 0);
      chk("t1_hold", 32'(dut0.r_state), 32'(S_HOLD));
      tick();
      chk("t1_pulse_end", 32'(bus0.o_pulse), 0);
      chk("t1_wait", 32'(dut0.r_state), 32'(S_WAIT));
      tick();
      chk("t1_idle", 32'(dut0.r_state), 32'(S_IDLE));

      // burst of 5 with busy held 10 cycles after each issue
      pc0 = 0; pk0 = 0; b2b = 0; auto_busy = 1;
      for (int i = 0; i < 5; i++) begin
         bus0.i_pulse = 1;
         tick();
      end
      bus0.i_pulse = 0;
      repeat (90) tick();
      auto_busy = 0;
      bus0.i_busy = 0;
      chk("t2_count", 32'(pc0), 5);
      chk("t2_peak", 32'(pk0), 4);
      chk("t2_ovf", 32'(bus0.o_ovf), 0);
      chk("t2_pend", 32'(bus0.o_pending), 0);

      // CNT_W=2 overflow with busy stuck high
      bus1.i_busy = 1;
      for (int i = 0; i < 6; i++) begin
         bus1.i_pulse = 1;
         tick();
      end
      bus1.i_pulse = 0;
      chk("t3_pend", 32'(bus1.o_pending), 3);
      chk("t3_ovf", 32'(bus1.o_ovf), 1);
      chk("t3_drop", 32'(bus1.o_drop_cnt), STATS ? 3 : 0);

      // issue coincides with a pulse at all-ones
      bus1.i_busy = 0;
      bus1.i_pulse = 1;
      tick();
      bus1.i_pulse = 0;
      chk("t4_pend", 32'(bus1.o_pending), 3);
      chk("t4_pulse", 32'(bus1.o_pulse), 1);
      chk("t4_ovf", 32'(bus1.o_ovf), 1);
      chk("t4_drop", 32'(bus1.o_drop_cnt), STATS ? 3 : 0);
      pc1 = 0;
      repeat (15) tick();
      chk("t4_drain", 32'(pc1), 3);
      chk("t4_pend0", 32'(bus1.o_pending), 0);

      // clear coinciding with a drop
      bus1.i_busy = 1;
      for (int i = 0; i < 3; i++) begin
         bus1.i_pulse = 1;
         tick();
      end
      bus1.i_clr_ovf = 1;
      tick();
      bus1.i_pulse = 0;
      chk("t5_ovf", 32'(bus1.o_ovf), 1);
      chk("t5_drop", 32'(bus1.o_drop_cnt), STATS ? 1 : 0);
      chk("t5_pend", 32'(bus1.o_pending), 3);
      tick();
      bus1.i_clr_ovf = 0;
      chk("t5_clr_ovf", 32'(bus1.o_ovf), 0);
      chk("t5_clr_drop", 32'(bus1.o_drop_cnt), 0);
      bus1.i_busy = 0;
      repeat (15) tick();

      // async reset while waiting with 4 pending
      bus0.i_busy = 0;
      for (int i = 0; i < 5; i++) begin
         bus0.i_pulse = 1;
         tick();
         if (i == 1) bus0.i_busy = 1;
      end
      bus0.i_pulse = 0;
      chk("t6_pend", 32'(bus0.o_pending), 4);
      chk("t6_wait", 32'(dut0.r_state), 32'(S_WAIT));
      #2 i_rst = 1;
      #1;
      chk("t6_rst_pend", 32'(bus0.o_pending), 0);
      chk("t6_rst_pulse", 32'(bus0.o_pulse), 0);
      chk("t6_rst_ovf", 32'(bus0.o_ovf), 0);
      chk("t6_rst_state", 32'(dut0.r_state), 32'(S_IDLE));
      #1 i_rst = 0;
      bus0.i_busy = 0;
      pc0 = 0;
      repeat (10) tick();
      chk("t6_silent", 32'(pc0), 0);
      chk("b2b", 32'(b2b), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
